// File: rtl/systolic_drain_pkg.sv
// Shared types for the result_drain readback engine: FSM state encoding and
// skid FIFO depth.
package systolic_drain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } drain_state_e;

  localparam int unsigned DRAIN_FIFO_DEPTH = 2;

endpackage

// File: rtl/result_drain_fifo.sv
// Two-entry FIFO with a registered head: the first word pushed into an empty
// FIFO appears on head_data in the following cycle.
module result_drain_fifo
  import systolic_drain_pkg::*;
#(
  parameter int unsigned WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       occupancy,
  output logic             empty
);

  localparam logic [1:0] FULL_OCC = 2'(DRAIN_FIFO_DEPTH);

  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic [1:0]       occ_q;
  logic             do_pop;
  logic             do_push;

  assign do_pop  = pop && (occ_q != 2'd0);
  assign do_push = push && ((occ_q != FULL_OCC) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else if (do_push && do_pop) begin
      if (occ_q == 2'd1) begin
        head_q <= push_data;
      end else begin
        head_q <= tail_q;
        tail_q <= push_data;
      end
    end else if (do_push) begin
      if (occ_q == 2'd0) begin
        head_q <= push_data;
      end else begin
        tail_q <= push_data;
      end
      occ_q <= occ_q + 2'd1;
    end else if (do_pop) begin
      // Draining to empty keeps the last word on the head register.
      if (occ_q == FULL_OCC) begin
        head_q <= tail_q;
      end
      occ_q <= occ_q - 2'd1;
    end
  end

  assign head_data = head_q;
  assign occupancy = occ_q;
  assign empty     = (occ_q == 2'd0);

endmodule

// File: rtl/result_drain.sv
// O-memory readback sequencer: walks base..base+count-1 and streams the words
// out as valid/ready with a last marker. RESULT_DRAIN_AUTOSTART_EN adds ap_done autostart.
module result_drain
  import systolic_drain_pkg::*;
#(
  parameter int unsigned RESULT_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH   = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    drain_start,
  input  logic [ADDR_WIDTH-1:0]   cfg_base,
  input  logic [ADDR_WIDTH:0]     cfg_count,
  input  logic                    ap_done,
  output logic [ADDR_WIDTH-1:0]   addrO,
  input  logic [RESULT_WIDTH-1:0] dataO,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [RESULT_WIDTH-1:0] m_data,
  output logic                    m_last,
  output logic                    drain_busy,
  output logic                    drain_done
);

  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  drain_state_e            state_q, state_d;
  logic [ADDR_WIDTH:0]     count_q;
  logic [ADDR_WIDTH:0]     issued_q;
  logic [ADDR_WIDTH:0]     cap_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    inflight_q;
  logic                    done_q;

  logic                    start_req;
  logic                    start_acc;
  logic                    pop;
  logic                    issue;
  logic                    issue_last;
  logic                    credit_ok;
  logic [2:0]              credit_load;
  logic                    final_hs;

  logic [RESULT_WIDTH:0]   fifo_head;
  logic [1:0]              fifo_occ;
  logic                    fifo_empty;
  logic                    cap_last;

`ifdef RESULT_DRAIN_AUTOSTART_EN
  logic ap_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ap_done_q <= 1'b0;
    end else begin
      ap_done_q <= ap_done;
    end
  end

  assign start_req = drain_start || (ap_done && !ap_done_q);
`else
  logic unused_ap_done;
  assign unused_ap_done = ap_done;
  assign start_req      = drain_start;
`endif

  assign start_acc = (state_q == IDLE) && start_req;
  assign pop       = m_valid && m_ready;

  // A read issued now lands in the FIFO on the next edge, so reserve a slot
  // for it against the word already in flight, crediting this cycle's pop.
  assign credit_load = {1'b0, fifo_occ} + {2'b0, inflight_q};
  assign credit_ok   = credit_load < (3'd2 + {2'b0, pop});

  assign issue      = (state_q == RUN) && (issued_q < count_q) && credit_ok;
  assign issue_last = issue && ((issued_q + CNT_ONE) == count_q);
  assign final_hs   = (state_q == FLUSH) && pop && m_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_acc && (cfg_count != '0)) state_d = RUN;
      RUN:     if (issue_last) state_d = FLUSH;
      FLUSH:   if (final_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // addrO always holds the next address to read; an issue in RUN commits the
  // read the memory samples at this edge, then advances unless it was the last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      issued_q   <= '0;
      cap_q      <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      inflight_q <= issue;
      done_q     <= (start_acc && (cfg_count == '0)) || final_hs;
      if (start_acc) begin
        count_q  <= cfg_count;
        issued_q <= '0;
        cap_q    <= '0;
        addr_q   <= cfg_base;
      end else begin
        if (issue) begin
          issued_q <= issued_q + CNT_ONE;
          if (!issue_last) begin
            addr_q <= addr_q + ADDR_ONE;
          end
        end
        if (inflight_q) begin
          cap_q <= cap_q + CNT_ONE;
        end
      end
    end
  end

  assign cap_last = (cap_q == (count_q - CNT_ONE));

  result_drain_fifo #(
    .WIDTH(RESULT_WIDTH + 1)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data ({cap_last, dataO}),
    .pop       (pop),
    .head_data (fifo_head),
    .occupancy (fifo_occ),
    .empty     (fifo_empty)
  );

  assign addrO      = addr_q;
  assign m_valid    = !fifo_empty;
  assign m_data     = fifo_head[RESULT_WIDTH-1:0];
  assign m_last     = fifo_head[RESULT_WIDTH] && !fifo_empty;
  assign drain_busy = (state_q != IDLE);
  assign drain_done = done_q;

endmodule

// File: tb/tb_result_drain.sv
// Self-checking bench for result_drain: vector table of drains plus hand-written
// zero-count, ap_done and mid-drain reset sequences, checked against a scoreboard.
module tb_result_drain;

  localparam int unsigned RW = 16;
  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          drain_start = 1'b0;
  logic          ap_done = 1'b0;
  logic          m_ready = 1'b0;
  logic [AW-1:0] cfg_base = '0;
  logic [AW:0]   cfg_count = '0;
  logic [AW-1:0] addrO;
  logic [RW-1:0] dataO = '0;
  logic [RW-1:0] m_data;
  logic          m_valid, m_last, drain_busy, drain_done;

  result_drain #(.RESULT_WIDTH(RW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .drain_start(drain_start), .cfg_base(cfg_base),
    .cfg_count(cfg_count), .ap_done(ap_done), .addrO(addrO), .dataO(dataO),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .drain_busy(drain_busy), .drain_done(drain_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0] data;
    logic          last;
  } exp_t;

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   cnt;
    int            mode;      // 0: ready high, 1: toggle, 2: random
    bit            restart;   // pulse drain_start mid-drain
    int            exp_lat;   // start to first m_valid, in cycles
  } vec_t;

  exp_t sbq[$];
  int   n_checks = 0, n_pass = 0, cyc = 0;
  int   first_valid_cyc = -1, first_hs = -1, last_hs = -1, hs_cnt = 0;
  int   done_cnt = 0, done_cyc = 0;
  bit   busy_seen = 0, valid_seen = 0, prev_stall = 0;
  logic [RW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  function automatic logic [RW-1:0] mem_word(input logic [AW-1:0] a);
    return 16'(a) + 16'd100;
  endfunction

  always @(posedge clk) dataO <= mem_word(addrO);
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (drain_busy) busy_seen = 1;
      if (m_valid) begin
        valid_seen = 1;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (prev_stall) begin
        check("stall_valid_held", m_valid, 1);
        check("stall_data_held", m_data, prev_data);
        check("stall_last_held", m_last, prev_last);
      end
      if (m_valid && m_ready) begin
        check("word_expected", sbq.size() > 0, 1);
        if (sbq.size() > 0) begin
          exp_t e;
          e = sbq.pop_front();
          check("data", m_data, e.data);
          check("last", m_last, e.last);
        end
        hs_cnt++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
      end
      if (drain_done) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_low_at_done", drain_busy, 0);
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end else begin
      prev_stall = 0;
    end
  end

  task automatic load_sb(input logic [AW-1:0] base, input logic [AW:0] cnt);
    for (int i = 0; i < int'(cnt); i++) begin
      exp_t e;
      e.data = mem_word(base + AW'(i));
      e.last = (i == int'(cnt) - 1);
      sbq.push_back(e);
    end
    first_valid_cyc = -1; first_hs = -1; last_hs = -1; hs_cnt = 0;
  endtask

  task automatic run_drain(input vec_t v, input bit use_ap);
    int start_cyc, d0, budget;
    budget = int'(v.cnt) * 4 + 20;
    @(posedge clk); #1;
    cfg_base = v.base; cfg_count = v.cnt;
    if (use_ap) ap_done = 1'b1; else drain_start = 1'b1;
    load_sb(v.base, v.cnt);
    d0 = done_cnt; start_cyc = cyc;
    m_ready = (v.mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int c = 0; c < budget; c++) begin
      if (done_cnt != d0) break;
      @(posedge clk); #1;
      if (v.restart && c == 4) begin
        drain_start = 1'b1; cfg_base = v.base + 10'd100; cfg_count = 11'd3;
      end else begin
        drain_start = 1'b0; cfg_base = v.base; cfg_count = v.cnt;
      end
      case (v.mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ~m_ready;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
    drain_start = 1'b0; ap_done = 1'b0; m_ready = 1'b1;
    check("done_count", done_cnt - d0, 1);
    check("first_valid_latency", first_valid_cyc - start_cyc, v.exp_lat);
    check("word_count", hs_cnt, v.cnt);
    check("scoreboard_empty", sbq.size(), 0);
    check("done_after_last", done_cyc - last_hs, 1);
    if (v.mode == 0) check("no_gaps", last_hs - first_hs, int'(v.cnt) - 1);
    check("busy_after_done", drain_busy, 0);
    sbq.delete();
  endtask

  vec_t vecs[6];

  initial begin
    int d0, start_cyc;
    vec_t v;
    vecs[0] = '{base: 10'd0,    cnt: 11'd16, mode: 0, restart: 0, exp_lat: 3};
    vecs[1] = '{base: 10'd1020, cnt: 11'd8,  mode: 0, restart: 0, exp_lat: 3};
    vecs[2] = '{base: 10'd50,   cnt: 11'd5,  mode: 1, restart: 0, exp_lat: 3};
    vecs[3] = '{base: 10'd300,  cnt: 11'd10, mode: 0, restart: 1, exp_lat: 3};
    vecs[4] = '{base: 10'd512,  cnt: 11'd12, mode: 2, restart: 0, exp_lat: 3};
    vecs[5] = '{base: 10'd1023, cnt: 11'd1,  mode: 0, restart: 0, exp_lat: 3};

    repeat (3) @(posedge clk);
    #1;
    check("rst_addrO", addrO, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    check("rst_busy", drain_busy, 0);
    check("rst_done", drain_done, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) run_drain(vecs[i], 1'b0);

    // Zero-length drain: done pulse only.
    @(posedge clk); #1;
    cfg_count = '0; cfg_base = 10'd77; drain_start = 1'b1;
    busy_seen = 0; valid_seen = 0; d0 = done_cnt; start_cyc = cyc;
    @(posedge clk); #1;
    drain_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("zero_done_count", done_cnt - d0, 1);
    check("zero_done_latency", done_cyc - start_cyc, 1);
    check("zero_busy_seen", busy_seen, 0);
    check("zero_valid_seen", valid_seen, 0);

`ifdef RESULT_DRAIN_AUTOSTART_EN
    v = '{base: 10'd200, cnt: 11'd4, mode: 0, restart: 0, exp_lat: 3};
    run_drain(v, 1'b1);
`else
    @(posedge clk); #1;
    cfg_base = 10'd200; cfg_count = 11'd4; ap_done = 1'b1;
    busy_seen = 0; valid_seen = 0; d0 = done_cnt;
    repeat (6) @(posedge clk);
    #1;
    ap_done = 1'b0;
    check("ap_done_ignored_busy", busy_seen, 0);
    check("ap_done_ignored_valid", valid_seen, 0);
    check("ap_done_ignored_done", done_cnt - d0, 0);
`endif

    // Reset after the third word of a 10-word drain.
    @(posedge clk); #1;
    cfg_base = 10'd40; cfg_count = 11'd10; drain_start = 1'b1; m_ready = 1'b1;
    load_sb(10'd40, 11'd10);
    d0 = done_cnt;
    for (int c = 0; c < 40 && hs_cnt < 3; c++) begin
      @(posedge clk); #1;
      drain_start = 1'b0;
    end
    check("pre_reset_words", hs_cnt, 3);
    rst_n = 1'b0;
    #1;
    check("midrst_addrO", addrO, 0);
    check("midrst_m_valid", m_valid, 0);
    check("midrst_m_data", m_data, 0);
    check("midrst_m_last", m_last, 0);
    check("midrst_busy", drain_busy, 0);
    check("midrst_done", drain_done, 0);
    sbq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("no_done_after_reset", done_cnt - d0, 0);
    v = '{base: 10'd7, cnt: 11'd2, mode: 0, restart: 0, exp_lat: 3};
    run_drain(v, 1'b0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
